// File: rtl/branch_resolve_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared definitions for the EX-stage branch resolve unit and the GShare
// fetch predictor that consumes its update bus.
//   bcond_e      : predictor update class; bit0 is the outcome bit the
//                  predictor shifts into its global history.
//   bru_ctrl_t   : control-flow flags decoded in ID and carried into EX.
//   BRU_INSN_BYTES : fixed instruction size used for the fall-through PC.
// ----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        BCOND_NONE      = 2'b00,
        BCOND_NOT_TAKEN = 2'b10,
        BCOND_TAKEN     = 2'b11
    } bcond_e;

    typedef struct packed {
        logic is_branch;
        logic is_jal;
        logic is_jalr;
    } bru_ctrl_t;

    localparam int unsigned BRU_CTRL_W     = $bits(bru_ctrl_t);
    localparam int unsigned BRU_INSN_BYTES = 4;

endpackage

// File: rtl/bru_target_calc.sv
// ----------------------------------------------------------------------------
// bru_target_calc
// Combinational actual-next-PC computation and prediction compare for the
// instruction currently in EX.
// Ports:
//   i_valid      : ID/EX entry holds a real instruction
//   i_pc         : PC of the EX instruction
//   i_pred       : next PC that fetch predicted for it
//   i_ctrl       : branch / jal / jalr flags
//   i_imm        : sign-extended immediate
//   i_cmp_taken  : branch comparator result
//   i_rs1        : forwarded rs1 value
//   o_actual     : actual next PC (0 for a bubble)
//   o_mispredict : valid and actual differs from the prediction
//   o_bcond      : predictor update class
// ----------------------------------------------------------------------------
module bru_target_calc
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pred,
    input  bru_ctrl_t       i_ctrl,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_cmp_taken,
    input  logic [XLEN-1:0] i_rs1,
    output logic [XLEN-1:0] o_actual,
    output logic            o_mispredict,
    output bcond_e          o_bcond
);

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus_imm;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_actual;

    always_comb begin
        w_pc_plus4    = i_pc + XLEN'(BRU_INSN_BYTES);
        w_pc_plus_imm = i_pc + i_imm;
        w_jalr_target = (i_rs1 + i_imm) & ~XLEN'(1);

        w_actual = w_pc_plus4;
        if (i_ctrl.is_jalr) begin
            w_actual = w_jalr_target;
        end else if (i_ctrl.is_jal) begin
            w_actual = w_pc_plus_imm;
        end else if (i_ctrl.is_branch && i_cmp_taken) begin
            w_actual = w_pc_plus_imm;
        end
    end

    always_comb begin
        // Bubbles drive zeros so the update bus is quiet when nothing resolves.
        o_actual     = i_valid ? w_actual : '0;
        o_mispredict = i_valid && (w_actual != i_pred);
        o_bcond      = BCOND_NONE;
        if (i_valid) begin
            if (i_ctrl.is_jal || i_ctrl.is_jalr) begin
                o_bcond = BCOND_TAKEN;
            end else if (i_ctrl.is_branch) begin
                o_bcond = i_cmp_taken ? BCOND_TAKEN : BCOND_NOT_TAKEN;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Carries each fetched instruction's predicted next PC through IF/ID and
// ID/EX, resolves the actual next PC in EX, redirects fetch and flushes the
// two younger stages on a misprediction, and drives the predictor update bus.
// Optional macro: BRU_STATS_EN adds saturating statistics counters
// (parameter CNT_W, outputs stat_branches / stat_mispredicts / stat_cycles).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   if_valid/pc/pred      : instruction in IF and its predicted next PC
//   stall                 : hold IF/ID, bubble into ID/EX
//   id_is_*/id_imm        : decode info of the instruction in IF/ID
//   ex_cmp_taken, ex_rs1  : EX comparator result and forwarded rs1
//   mispredict            : EX prediction wrong (combinational)
//   redirect_pc           : correct next PC for fetch
//   flush_if_id/id_ex     : squash the younger stages
//   upd_bcond/pc/correct_next_pc : predictor update bus
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
`ifdef BRU_STATS_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pred_next_pc,
    input  logic            stall,
    input  logic            id_is_branch,
    input  logic            id_is_jal,
    input  logic            id_is_jalr,
    input  logic [XLEN-1:0] id_imm,
    input  logic            ex_cmp_taken,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic [1:0]      upd_bcond,
    output logic [XLEN-1:0] upd_pc,
    output logic [XLEN-1:0] upd_correct_next_pc
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts,
    output logic [CNT_W-1:0] stat_cycles
`endif
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred;
    } ifid_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred;
        bru_ctrl_t       ctrl;
        logic [XLEN-1:0] imm;
    } idex_t;

    ifid_t     r_ifid;
    idex_t     r_idex;
    bru_ctrl_t w_id_ctrl;
    logic      w_mispredict;
    bcond_e    w_bcond;
    logic [XLEN-1:0] w_actual;

    assign w_id_ctrl = '{is_branch: id_is_branch, is_jal: id_is_jal, is_jalr: id_is_jalr};

    // Mispredict beats stall: the flushed entries are wrong-path either way.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid <= '0;
            r_idex <= '0;
        end else if (w_mispredict) begin
            r_ifid.valid <= 1'b0;
            r_idex.valid <= 1'b0;
        end else if (stall) begin
            r_idex.valid <= 1'b0;
        end else begin
            r_ifid.valid <= if_valid;
            r_ifid.pc    <= if_pc;
            r_ifid.pred  <= if_pred_next_pc;
            r_idex.valid <= r_ifid.valid;
            r_idex.pc    <= r_ifid.pc;
            r_idex.pred  <= r_ifid.pred;
            r_idex.ctrl  <= w_id_ctrl;
            r_idex.imm   <= id_imm;
        end
    end

    bru_target_calc #(
        .XLEN (XLEN)
    ) u_target_calc (
        .i_valid      (r_idex.valid),
        .i_pc         (r_idex.pc),
        .i_pred       (r_idex.pred),
        .i_ctrl       (r_idex.ctrl),
        .i_imm        (r_idex.imm),
        .i_cmp_taken  (ex_cmp_taken),
        .i_rs1        (ex_rs1),
        .o_actual     (w_actual),
        .o_mispredict (w_mispredict),
        .o_bcond      (w_bcond)
    );

    assign mispredict          = w_mispredict;
    assign redirect_pc         = w_actual;
    assign flush_if_id         = w_mispredict;
    assign flush_id_ex         = w_mispredict;
    assign upd_bcond           = w_bcond;
    assign upd_pc              = r_idex.pc;
    assign upd_correct_next_pc = w_actual;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;
    logic [CNT_W-1:0] r_stat_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
            r_stat_cycles      <= '0;
        end else begin
            if ((w_bcond != BCOND_NONE) && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + 1'b1;
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
            end
            if (r_stat_cycles != '1) begin
                r_stat_cycles <= r_stat_cycles + 1'b1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
    assign stat_cycles      = r_stat_cycles;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit with hand-computed expectations.
// With BRU_STATS_EN defined, the DUT is built with CNT_W=4 and the
// statistics counters are checked as well.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pred_next_pc;
    logic        stall;
    logic        id_is_branch;
    logic        id_is_jal;
    logic        id_is_jalr;
    logic [31:0] id_imm;
    logic        ex_cmp_taken;
    logic [31:0] ex_rs1;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [1:0]  upd_bcond;
    logic [31:0] upd_pc;
    logic [31:0] upd_correct_next_pc;
`ifdef BRU_STATS_EN
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;
    logic [3:0]  stat_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    branch_resolve_unit #(
        .XLEN (32)
`ifdef BRU_STATS_EN
        ,
        .CNT_W (4)
`endif
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .if_valid            (if_valid),
        .if_pc               (if_pc),
        .if_pred_next_pc     (if_pred_next_pc),
        .stall               (stall),
        .id_is_branch        (id_is_branch),
        .id_is_jal           (id_is_jal),
        .id_is_jalr          (id_is_jalr),
        .id_imm              (id_imm),
        .ex_cmp_taken        (ex_cmp_taken),
        .ex_rs1              (ex_rs1),
        .mispredict          (mispredict),
        .redirect_pc         (redirect_pc),
        .flush_if_id         (flush_if_id),
        .flush_id_ex         (flush_id_ex),
        .upd_bcond           (upd_bcond),
        .upd_pc              (upd_pc),
        .upd_correct_next_pc (upd_correct_next_pc)
`ifdef BRU_STATS_EN
        ,
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts),
        .stat_cycles         (stat_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change only here, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_is_branch = 1'b0;
        id_is_jal    = 1'b0;
        id_is_jalr   = 1'b0;
        id_imm       = '0;
    endtask

    // Push one instruction through IF and ID; on return it sits in EX.
    task automatic issue(input logic [31:0] pc, input logic [31:0] pred, input logic br,
                         input logic jal, input logic jalr, input logic [31:0] imm);
        if_valid        = 1'b1;
        if_pc           = pc;
        if_pred_next_pc = pred;
        step();
        if_valid     = 1'b0;
        id_is_branch = br;
        id_is_jal    = jal;
        id_is_jalr   = jalr;
        id_imm       = imm;
        step();
        clear_id();
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_mp"}, 64'(mispredict), 64'd0);
        check_eq({tag, "_bc"}, 64'(upd_bcond), 64'd0);
    endtask

    initial begin
        reset           = 1'b1;
        if_valid        = 1'b0;
        if_pc           = '0;
        if_pred_next_pc = '0;
        stall           = 1'b0;
        ex_cmp_taken    = 1'b0;
        ex_rs1          = '0;
        clear_id();
        step();
        step();

        // Reset state
        check_eq("rst_mp", 64'(mispredict), 64'd0);
        check_eq("rst_fl", 64'({flush_if_id, flush_id_ex}), 64'd0);
        check_eq("rst_bc", 64'(upd_bcond), 64'd0);
        check_eq("rst_rd", 64'(redirect_pc), 64'd0);
        check_eq("rst_up", 64'(upd_pc), 64'd0);
        check_eq("rst_cn", 64'(upd_correct_next_pc), 64'd0);
        reset = 1'b0;
        step();

        // Not-taken branch, correctly predicted
        issue(32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 32'h40);
        ex_cmp_taken = 1'b0;
        #1;
        check_eq("nt_mp", 64'(mispredict), 64'd0);
        check_eq("nt_bc", 64'(upd_bcond), 64'h2);
        check_eq("nt_up", 64'(upd_pc), 64'h100);
        check_eq("nt_cn", 64'(upd_correct_next_pc), 64'h104);
        step();

        // Taken branch mispredicted as fall-through, with younger work behind it
        if_valid = 1'b1; if_pc = 32'h100; if_pred_next_pc = 32'h104;
        step();
        if_pc = 32'h104; if_pred_next_pc = 32'h108;
        id_is_branch = 1'b1; id_imm = 32'h40;
        step();
        if_pc = 32'h108; if_pred_next_pc = 32'h10c;
        id_is_branch = 1'b1; id_imm = 32'h0;
        ex_cmp_taken = 1'b1;
        #1;
        check_eq("tk_mp", 64'(mispredict), 64'd1);
        check_eq("tk_rd", 64'(redirect_pc), 64'h140);
        check_eq("tk_fl", 64'({flush_if_id, flush_id_ex}), 64'h3);
        check_eq("tk_bc", 64'(upd_bcond), 64'h3);
        step();
        if_valid = 1'b0;
        ex_cmp_taken = 1'b0;
        #1;
        check_quiet("tk_sq1");
        step();
        check_quiet("tk_sq2");
        clear_id();
        step();

        // JALR: target low bit is cleared
        issue(32'h200, 32'h1007, 1'b0, 1'b0, 1'b1, 32'h4);
        ex_rs1 = 32'h1003;
        #1;
        check_eq("jalr_mp", 64'(mispredict), 64'd1);
        check_eq("jalr_rd", 64'(redirect_pc), 64'h1006);
        check_eq("jalr_bc", 64'(upd_bcond), 64'h3);
        step();
        ex_rs1 = '0;

        // Non-branch with a stale target prediction
        issue(32'h300, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("nb_mp", 64'(mispredict), 64'd1);
        check_eq("nb_rd", 64'(redirect_pc), 64'h304);
        check_eq("nb_bc", 64'(upd_bcond), 64'h0);
        step();

        // JAL with negative offset, correctly predicted
        issue(32'h600, 32'h5f0, 1'b0, 1'b1, 1'b0, 32'hffff_fff0);
        #1;
        check_eq("jal_mp", 64'(mispredict), 64'd0);
        check_eq("jal_bc", 64'(upd_bcond), 64'h3);
        check_eq("jal_cn", 64'(upd_correct_next_pc), 64'h5f0);
        step();

        // Fall-through wraps modulo 2^32
        issue(32'hffff_fffc, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8);
        #1;
        check_eq("wrap_mp", 64'(mispredict), 64'd0);
        check_eq("wrap_cn", 64'(upd_correct_next_pc), 64'h0);
        step();

        // Plain stall: IF/ID holds, a bubble goes to EX, then the entry proceeds
        if_valid = 1'b1; if_pc = 32'h800; if_pred_next_pc = 32'h804;
        step();
        if_valid = 1'b0; stall = 1'b1; id_is_branch = 1'b1;
        step();
        check_quiet("st_bub");
        stall = 1'b0;
        step();
        clear_id();
        #1;
        check_eq("st_bc", 64'(upd_bcond), 64'h2);
        check_eq("st_up", 64'(upd_pc), 64'h800);
        step();

        // Mispredict during a stall still flushes the held IF/ID entry
        if_valid = 1'b1; if_pc = 32'h400; if_pred_next_pc = 32'h404;
        step();
        if_pc = 32'h404; if_pred_next_pc = 32'h408;
        id_is_branch = 1'b1; id_imm = 32'h20;
        step();
        if_valid = 1'b0; stall = 1'b1;
        id_is_branch = 1'b1; id_imm = 32'h10;
        ex_cmp_taken = 1'b1;
        #1;
        check_eq("sm_mp", 64'(mispredict), 64'd1);
        check_eq("sm_rd", 64'(redirect_pc), 64'h420);
        step();
        ex_cmp_taken = 1'b0;
        #1;
        check_quiet("sm_q1");
        step();
        stall = 1'b0;
        #1;
        check_quiet("sm_q2");
        step();
        check_quiet("sm_q3");
        clear_id();
        step();

        // Reset asserted while a mispredict is flushing
        if_valid = 1'b1; if_pc = 32'h700; if_pred_next_pc = 32'h704;
        step();
        if_pc = 32'h704; if_pred_next_pc = 32'h708;
        id_is_branch = 1'b1; id_imm = 32'h80;
        step();
        if_valid = 1'b0; ex_cmp_taken = 1'b1; reset = 1'b1;
        #1;
        check_eq("rf_mp", 64'(mispredict), 64'd1);
        step();
        check_eq("rf_mp0", 64'(mispredict), 64'd0);
        check_eq("rf_fl0", 64'({flush_if_id, flush_id_ex}), 64'd0);
        check_eq("rf_bc0", 64'(upd_bcond), 64'd0);
        check_eq("rf_rd0", 64'(redirect_pc), 64'd0);
        check_eq("rf_up0", 64'(upd_pc), 64'd0);
        check_eq("rf_cn0", 64'(upd_correct_next_pc), 64'd0);
        reset = 1'b0; ex_cmp_taken = 1'b0;
        step();
        check_quiet("rf_post");
        clear_id();

`ifdef BRU_STATS_EN
        // Ten branches, the first three mispredicted
        reset = 1'b1;
        step();
        check_eq("stat_rst", 64'({stat_branches, stat_mispredicts, stat_cycles}), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue(32'h1000 + 32'(i * 16), 32'h1004 + 32'(i * 16), 1'b1, 1'b0, 1'b0, 32'h40);
            ex_cmp_taken = (i < 3);
            step();
            ex_cmp_taken = 1'b0;
        end
        check_eq("stat_br", 64'(stat_branches), 64'd10);
        check_eq("stat_mp", 64'(stat_mispredicts), 64'd3);
        check_eq("stat_cyc", 64'(stat_cycles), 64'd15);
        step();
        check_eq("stat_sat", 64'(stat_cycles), 64'd15);
        for (int i = 0; i < 8; i++) begin
            issue(32'h2000, 32'h2004, 1'b1, 1'b0, 1'b0, 32'h40);
            step();
        end
        check_eq("stat_brsat", 64'(stat_branches), 64'd15);
        check_eq("stat_mphold", 64'(stat_mispredicts), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
